fir_xifu_result_queue: RTL and testbench
========================================

# fir_xifu_result_queue

Result-side decoupling queue placed between the FIR XIFU writeback stage and the core's CV-X-IF result channel. It absorbs result transactions from writeback while the core holds `result_ready` low. It drops entries the core kills through the commit interface before they are offered. It preserves the order in which results were produced, so writeback never stalls on core backpressure unless the queue is full.

## Interface
- `DEPTH`, 4: number of result entries, power of two, ≥2
- `ID_WIDTH`, 4: X-IF instruction id width
- `DATA_WIDTH`, 32: writeback data width (X_RFW_WIDTH)

- `clk_i` in 1: clock
- `rst_ni` in 1: asynchronous active-low reset
- `clear_i` in 1: synchronous flush of all entries, same as the pipeline kill
- `in_valid_i` in 1: writeback offers a result
- `in_ready_o` out 1: queue accepts the result (`count < DEPTH`)
- `in_id_i` in ID_WIDTH: instruction id
- `in_data_i` in DATA_WIDTH: result data
- `in_rd_i` in 5: destination register
- `in_we_i` in 1: register write enable
- `commit_valid_i` in 1: commit transaction valid
- `commit_id_i` in ID_WIDTH: committed/killed id
- `commit_kill_i` in 1: instruction is killed
- `result_valid_o` out 1: result offered to the core
- `result_ready_i` in 1: core accepts the result
- `result_id_o` out ID_WIDTH: head id
- `result_data_o` out DATA_WIDTH: head data
- `result_rd_o` out 5: head rd
- `result_we_o` out 1: head we
- `count_o` out $clog2(DEPTH)+1: occupied entries, killed entries included

## Operation
- Circular buffer with write pointer, read pointer and count. Each entry stores id, data, rd, we, an `alive` flag and a `presented` flag.
- Push when `in_valid_i && in_ready_o`: write at wptr with `alive=1`, `presented=0`, then advance wptr. Pointers wrap modulo DEPTH.
- `in_ready_o = (count_o != DEPTH)`. There is no pop-through while full: a full queue refuses a push even if the head pops in the same cycle.
- Head handling:
  - If the head entry is alive: `result_valid_o=1` and the `result_*` outputs come combinationally from the head.
  - If the head entry is not alive: `result_valid_o=0`, and the entry is discarded in that cycle (rptr++, count--).
  - At most one head pop per cycle, whether it is a handshake or a discard.
- Handshake: pop when `result_valid_o && result_ready_i`. If `result_valid_o && !result_ready_i`, set the head's `presented` flag.
- Kill: when `commit_valid_i && commit_kill_i`, clear `alive` on every stored entry with `id == commit_id_i` that has `presented=0`.
  - A presented head ignores the kill. This keeps the X-IF rule that valid, once raised, stays high until ready.
  - A push carrying the same id in the same cycle is stored with `alive=0`.
- A commit with `commit_kill_i=0` has no effect; entries are already committed work.
- `clear_i` sets count=0 and wptr=rptr=0. Any push or pop in that cycle is ignored, and presented entries are dropped too.
- Simultaneous push and pop: count is unchanged, and both pointers advance.

## Timing
- Reset: count, wptr and rptr = 0; every entry has `alive=0` and `presented=0`. Outputs after reset: `result_valid_o=0`, `result_*` data = 0, `in_ready_o=1`, `count_o=0`.
- Latency: a result pushed at edge N is offered (`result_valid_o=1`) in the cycle after edge N. There is no same-cycle bypass.
- A kill sampled at edge N removes the target from presentation in the cycle after N. A killed head is discarded one cycle after it becomes head.
- Throughput: one push and one pop per cycle. Each killed entry at the head costs one bubble cycle.
- `in_ready_o` and `result_valid_o` depend only on registered state. There is no combinational path from `result_ready_i` to `in_ready_o`.
- Reset asserted mid-transfer returns the block to the reset state immediately; the in-flight result is lost.

## Test plan
- Single result: push id=3, data=0xDEADBEEF, rd=5, we=1 with `result_ready_i=1`. The result appears with `result_valid_o=1` exactly one cycle later and pops; `count_o` goes 1 then 0.
- Backpressure/full: hold `result_ready_i=0` and push 5 results with DEPTH=4.
  - `in_ready_o` goes low after the 4th push, and `result_valid_o` plus all outputs stay stable.
  - Release ready: ids come out in order 0,1,2,3, then the 5th enters.
- Kill in middle: queue ids 1,2,3, then kill id=2 while head 1 is stalled. The output sequence is 1, one bubble, then 3; `count_o` decrements correctly.
- Presented head: stall head id=4 so it is presented, then kill id=4. `result_valid_o` stays 1 and id 4 is still delivered on ready.
- Same-cycle kill and push: push id=7 while killing id=7 in the same cycle. The entry is never offered, and `count_o` returns to 0 two cycles later.
- Clear and reset: fill 3 entries, then pulse `clear_i` while pushing. Next cycle `count_o=0`, `result_valid_o=0`, `in_ready_o=1`. Asserting `rst_ni=0` mid-stream yields the same state asynchronously.

Source files
------------

// File: rtl/fir_xifu_result_queue_if.sv
// Result-queue handshake bundle: writeback push side, commit/kill side and X-IF result side.
// The queue takes the slave modport; the writeback/core environment takes master.
interface fir_xifu_result_queue_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [ID_WIDTH-1:0]   in_id_i;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic [4:0]            in_rd_i;
  logic                  in_we_i;

  logic                  commit_valid_i;
  logic [ID_WIDTH-1:0]   commit_id_i;
  logic                  commit_kill_i;

  logic                  result_valid_o;
  logic                  result_ready_i;
  logic [ID_WIDTH-1:0]   result_id_o;
  logic [DATA_WIDTH-1:0] result_data_o;
  logic [4:0]            result_rd_o;
  logic                  result_we_o;

  modport slave (
    input  in_valid_i, in_id_i, in_data_i, in_rd_i, in_we_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  result_ready_i,
    output in_ready_o,
    output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );

  modport master (
    output in_valid_i, in_id_i, in_data_i, in_rd_i, in_we_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output result_ready_i,
    input  in_ready_o,
    input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );
endinterface

// File: rtl/fir_xifu_result_queue.sv
// Ordered result queue between FIR XIFU writeback and the X-IF result channel; drops killed ids.
// One cycle push-to-offer latency; writeback is held off only when full (no pop-through when full).
module fir_xifu_result_queue #(
  parameter int DEPTH      = 4,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  fir_xifu_result_queue_if.slave   bus,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [4:0]            rd;
    logic                  we;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [DEPTH-1:0] alive_q, alive_d;
  logic [DEPTH-1:0] pres_q, pres_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t head;
  logic   not_empty;
  logic   head_alive;
  logic   push;
  logic   pop;
  logic   kill;
  logic   push_dead;

  assign not_empty  = (count_q != '0);
  assign head       = ent_q[rptr_q];
  assign head_alive = not_empty & alive_q[rptr_q];
  assign push       = bus.in_valid_i & (count_q != FULL);
  // A dead head is discarded regardless of result_ready_i, costing one bubble.
  assign pop        = not_empty & (~alive_q[rptr_q] | bus.result_ready_i);
  assign kill       = bus.commit_valid_i & bus.commit_kill_i;
  assign push_dead  = kill & (bus.in_id_i == bus.commit_id_i);

  always_comb begin
    ent_d   = ent_q;
    alive_d = alive_q;
    pres_d  = pres_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      alive_d = '0;
      pres_d  = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if ((ent_q[i].id == bus.commit_id_i) && !pres_q[i]) begin
            alive_d[i] = 1'b0;
          end
        end
      end
      // Once valid has been shown without ready, the head is pinned against kills.
      if (head_alive && !bus.result_ready_i) begin
        pres_d[rptr_q] = 1'b1;
      end
      if (pop) begin
        alive_d[rptr_q] = 1'b0;
        pres_d[rptr_q]  = 1'b0;
        rptr_d          = rptr_q + PTR_W'(1);
      end
      if (push) begin
        ent_d[wptr_q].id   = bus.in_id_i;
        ent_d[wptr_q].data = bus.in_data_i;
        ent_d[wptr_q].rd   = bus.in_rd_i;
        ent_d[wptr_q].we   = bus.in_we_i;
        alive_d[wptr_q]    = ~push_dead;
        pres_d[wptr_q]     = 1'b0;
        wptr_d             = wptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      alive_q <= '0;
      pres_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      alive_q <= alive_d;
      pres_q  <= pres_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready_o     = (count_q != FULL);
  assign bus.result_valid_o = head_alive;
  assign bus.result_id_o    = head_alive ? head.id   : '0;
  assign bus.result_data_o  = head_alive ? head.data : '0;
  assign bus.result_rd_o    = head_alive ? head.rd   : '0;
  assign bus.result_we_o    = head_alive & head.we;
  assign count_o            = count_q;

endmodule

// File: tb/tb_fir_xifu_result_queue.sv
// Bench for fir_xifu_result_queue: directed scenarios plus randomized traffic against a queue model.
module tb_fir_xifu_result_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] count;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  fir_xifu_result_queue_if #(.ID_WIDTH(4), .DATA_WIDTH(32)) bus ();

  fir_xifu_result_queue #(.DEPTH(4), .ID_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .bus     (bus.slave),
    .count_o (count)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    bit          alive;
    bit          presented;
  } ent_t;

  ent_t mq[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid_i     = 1'b0;
    bus.in_id_i        = '0;
    bus.in_data_i      = '0;
    bus.in_rd_i        = '0;
    bus.in_we_i        = 1'b0;
    bus.commit_valid_i = 1'b0;
    bus.commit_id_i    = '0;
    bus.commit_kill_i  = 1'b0;
    bus.result_ready_i = 1'b0;
    clear              = 1'b0;
  endtask

  task automatic set_push(input logic [3:0] id, input logic [31:0] data);
    bus.in_valid_i = 1'b1;
    bus.in_id_i    = id;
    bus.in_data_i  = data;
    bus.in_rd_i    = 5'(id + 4'd1);
    bus.in_we_i    = 1'b1;
  endtask

  task automatic set_kill(input logic [3:0] id);
    bus.commit_valid_i = 1'b1;
    bus.commit_kill_i  = 1'b1;
    bus.commit_id_i    = id;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.result_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.result_valid_o); else n_pass++;
    n_checks++; if (bus.in_ready_o !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", bus.in_ready_o); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
    n_checks++; if ({bus.result_id_o, bus.result_data_o, bus.result_rd_o, bus.result_we_o} !== 42'd0)
      $display("FAIL rst_data: got id=%h data=%h rd=%h we=%b want all 0", bus.result_id_o, bus.result_data_o, bus.result_rd_o, bus.result_we_o);
    else n_pass++;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    set_push(4'd3, 32'hDEADBEEF);
    bus.in_rd_i        = 5'd5;
    bus.result_ready_i = 1'b1;
    cyc();
    bus.in_valid_i = 1'b0;
    n_checks++; if (bus.result_valid_o !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.result_valid_o); else n_pass++;
    n_checks++; if (bus.result_id_o !== 4'd3 || bus.result_data_o !== 32'hDEADBEEF || bus.result_rd_o !== 5'd5 || bus.result_we_o !== 1'b1)
      $display("FAIL single_fields: got id=%0d data=%h rd=%0d we=%b want 3 deadbeef 5 1", bus.result_id_o, bus.result_data_o, bus.result_rd_o, bus.result_we_o);
    else n_pass++;
    n_checks++; if (count !== 3'd1) $display("FAIL single_count1: got %0d want 1", count); else n_pass++;
    cyc();
    n_checks++; if (count !== 3'd0 || bus.result_valid_o !== 1'b0) $display("FAIL single_drain: got count=%0d valid=%b want 0 0", count, bus.result_valid_o); else n_pass++;
    idle();
  endtask

  task automatic test_backpressure();
    int exp_cnt [5] = '{4, 3, 3, 2, 1};
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.in_ready_o !== 1'b1) $display("FAIL bp_ready_%0d: got %b want 1", i, bus.in_ready_o); else n_pass++;
      set_push(4'(i), 32'h100 + 32'(i));
      cyc();
    end
    set_push(4'd4, 32'h104);
    n_checks++; if (bus.in_ready_o !== 1'b0 || count !== 3'd4) $display("FAIL bp_full: got ready=%b count=%0d want 0 4", bus.in_ready_o, count); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_checks++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd0 || bus.result_data_o !== 32'h100 || count !== 3'd4)
        $display("FAIL bp_stable_%0d: got valid=%b id=%0d data=%h count=%0d want 1 0 100 4", k, bus.result_valid_o, bus.result_id_o, bus.result_data_o, count);
      else n_pass++;
    end
    bus.result_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'(k) || bus.result_data_o !== 32'h100 + 32'(k) || count !== 3'(exp_cnt[k]))
        $display("FAIL bp_order_%0d: got valid=%b id=%0d data=%h count=%0d want 1 %0d %h %0d", k, bus.result_valid_o, bus.result_id_o, bus.result_data_o, count, k, 32'h100 + 32'(k), exp_cnt[k]);
      else n_pass++;
      cyc();
      if (k == 1) bus.in_valid_i = 1'b0;
    end
    n_checks++; if (count !== 3'd0) $display("FAIL bp_empty: got %0d want 0", count); else n_pass++;
    idle();
  endtask

  task automatic test_kill_middle();
    for (int i = 1; i <= 3; i++) begin
      set_push(4'(i), 32'h200 + 32'(i));
      cyc();
    end
    bus.in_valid_i = 1'b0;
    set_kill(4'd2);
    cyc();
    idle();
    n_checks++; if (count !== 3'd3 || bus.result_id_o !== 4'd1 || bus.result_valid_o !== 1'b1)
      $display("FAIL km_hold: got count=%0d id=%0d valid=%b want 3 1 1", count, bus.result_id_o, bus.result_valid_o);
    else n_pass++;
    bus.result_ready_i = 1'b1;
    cyc();
    n_checks++; if (bus.result_valid_o !== 1'b0 || count !== 3'd2) $display("FAIL km_bubble: got valid=%b count=%0d want 0 2", bus.result_valid_o, count); else n_pass++;
    cyc();
    n_checks++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd3 || count !== 3'd1)
      $display("FAIL km_third: got valid=%b id=%0d count=%0d want 1 3 1", bus.result_valid_o, bus.result_id_o, count);
    else n_pass++;
    cyc();
    n_checks++; if (count !== 3'd0 || bus.result_valid_o !== 1'b0) $display("FAIL km_empty: got count=%0d valid=%b want 0 0", count, bus.result_valid_o); else n_pass++;
    idle();
  endtask

  task automatic test_presented_kill();
    set_push(4'd4, 32'h0000_4444);
    cyc();
    bus.in_valid_i = 1'b0;
    cyc();
    set_kill(4'd4);
    cyc();
    idle();
    n_checks++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd4 || bus.result_data_o !== 32'h4444)
      $display("FAIL pres_kept: got valid=%b id=%0d data=%h want 1 4 4444", bus.result_valid_o, bus.result_id_o, bus.result_data_o);
    else n_pass++;
    bus.result_ready_i = 1'b1;
    cyc();
    n_checks++; if (count !== 3'd0 || bus.result_valid_o !== 1'b0) $display("FAIL pres_pop: got count=%0d valid=%b want 0 0", count, bus.result_valid_o); else n_pass++;
    idle();
  endtask

  task automatic test_same_cycle_kill_push();
    bus.result_ready_i = 1'b1;
    set_push(4'd7, 32'h7777);
    set_kill(4'd7);
    cyc();
    idle();
    bus.result_ready_i = 1'b1;
    n_checks++; if (bus.result_valid_o !== 1'b0 || count !== 3'd1) $display("FAIL sck_stored_dead: got valid=%b count=%0d want 0 1", bus.result_valid_o, count); else n_pass++;
    cyc();
    n_checks++; if (bus.result_valid_o !== 1'b0 || count !== 3'd0) $display("FAIL sck_gone: got valid=%b count=%0d want 0 0", bus.result_valid_o, count); else n_pass++;
    idle();
  endtask

  task automatic test_clear();
    for (int i = 8; i <= 10; i++) begin
      set_push(4'(i), 32'(i));
      cyc();
    end
    n_checks++; if (count !== 3'd3) $display("FAIL clr_fill: got %0d want 3", count); else n_pass++;
    clear = 1'b1;
    set_push(4'd11, 32'hB);
    bus.result_ready_i = 1'b1;
    cyc();
    idle();
    n_checks++; if (count !== 3'd0 || bus.result_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1)
      $display("FAIL clr_state: got count=%0d valid=%b ready=%b want 0 0 1", count, bus.result_valid_o, bus.in_ready_o);
    else n_pass++;
    cyc();
    n_checks++; if (count !== 3'd0 || bus.result_valid_o !== 1'b0) $display("FAIL clr_no_push: got count=%0d valid=%b want 0 0", count, bus.result_valid_o); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 2; i++) begin
      set_push(4'(12 + i), 32'hC0 + 32'(i));
      cyc();
    end
    idle();
    n_checks++; if (count !== 3'd2) $display("FAIL rmid_fill: got %0d want 2", count); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || bus.result_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1)
      $display("FAIL rmid_async: got count=%0d valid=%b ready=%b want 0 0 1", count, bus.result_valid_o, bus.in_ready_o);
    else n_pass++;
    #1 rst_n = 1'b1;
    cyc();
  endtask

  task automatic model_step();
    bit   do_push;
    bit   do_pop;
    bit   kill;
    bit   set_pres;
    ent_t e;
    if (clear) begin
      mq.delete();
      return;
    end
    do_push  = bus.in_valid_i && (mq.size() < 4);
    do_pop   = (mq.size() > 0) && (!mq[0].alive || bus.result_ready_i);
    set_pres = (mq.size() > 0) && mq[0].alive && !bus.result_ready_i;
    kill     = bus.commit_valid_i && bus.commit_kill_i;
    if (kill) begin
      foreach (mq[i]) if (mq[i].id == bus.commit_id_i && !mq[i].presented) mq[i].alive = 1'b0;
    end
    if (set_pres) mq[0].presented = 1'b1;
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      e.id = bus.in_id_i; e.data = bus.in_data_i; e.rd = bus.in_rd_i; e.we = bus.in_we_i;
      e.alive = !(kill && bus.in_id_i == bus.commit_id_i);
      e.presented = 1'b0;
      mq.push_back(e);
    end
  endtask

  task automatic test_random();
    bit exp_valid;
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      exp_valid = (mq.size() > 0) && mq[0].alive;
      n_checks++; if (bus.result_valid_o !== exp_valid || bus.in_ready_o !== (mq.size() < 4) || count !== 3'(mq.size()))
        $display("FAIL rnd_ctrl cyc %0d: got valid=%b ready=%b count=%0d want %b %b %0d", c, bus.result_valid_o, bus.in_ready_o, count, exp_valid, mq.size() < 4, mq.size());
      else n_pass++;
      if (exp_valid) begin
        n_checks++; if (bus.result_id_o !== mq[0].id || bus.result_data_o !== mq[0].data || bus.result_rd_o !== mq[0].rd || bus.result_we_o !== mq[0].we)
          $display("FAIL rnd_head cyc %0d: got id=%0d data=%h rd=%0d we=%b want %0d %h %0d %b", c, bus.result_id_o, bus.result_data_o, bus.result_rd_o, bus.result_we_o, mq[0].id, mq[0].data, mq[0].rd, mq[0].we);
        else n_pass++;
      end
      bus.in_valid_i     = ($urandom_range(0, 9) < 7);
      bus.in_id_i        = 4'($urandom_range(0, 3));
      bus.in_data_i      = $urandom;
      bus.in_rd_i        = 5'($urandom_range(0, 31));
      bus.in_we_i        = 1'($urandom_range(0, 1));
      bus.result_ready_i = ($urandom_range(0, 9) < 5);
      bus.commit_valid_i = ($urandom_range(0, 9) < 3);
      bus.commit_kill_i  = 1'($urandom_range(0, 1));
      bus.commit_id_i    = 4'($urandom_range(0, 3));
      clear              = ($urandom_range(0, 49) == 0);
      @(posedge clk);
      model_step();
      #1;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_backpressure();
    test_kill_middle();
    test_presented_kill();
    test_same_cycle_kill_push();
    test_clear();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
